// File: rtl/fft_stage_sequencer.sv
// ---------------------------------------------------------------------------
// fft_stage_sequencer
//
// Control sequencer for a parallel-butterfly radix-2 DIT FFT datapath.
// Walks all N_LOG2 stages and, per stage, issues N/(2P) beats of P
// butterflies each. After the last beat of every stage it waits for all
// write-backs to come back before starting the next stage.
//
// Handshake: a beat transfers ("fires") on a rising ACLK edge where
// bf_valid and bf_ready are both high. Once bf_valid is raised it stays high,
// with bf_addr_a/bf_addr_b/bf_tw/bf_last held constant, until that beat
// fires. bf_ready may change freely. wb_ack is a single-cycle pulse per beat
// written back; an ack with no beat outstanding sets the sticky err flag.
//
// Ports:
//   ACLK, ARESET   clock, asynchronous active-high reset
//   start          begin a transform (only looked at while idle)
//   busy, done     transform running / one-cycle completion pulse
//   err            sticky spurious-write-back flag, cleared by start
//   stage          current stage index
//   bf_valid/bf_ready  beat handshake
//   bf_addr_a/b    per-lane upper/lower operand index (lane l at l*N_LOG2)
//   bf_tw          per-lane twiddle index (lane l at l*(N_LOG2-1))
//   bf_last        current beat is the final beat of its stage
//   wb_ack         write-back acknowledge, one pulse per beat
//   dbg_state_o    FSM state (0 IDLE, 1 ISSUE, 2 DRAIN, 3 DONE)
// ---------------------------------------------------------------------------
module fft_stage_sequencer #(
    parameter int N_LOG2 = 4,
    parameter int P      = 2
) (
    input  logic                       ACLK,
    input  logic                       ARESET,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic [N_LOG2-1:0]          stage,
    output logic                       bf_valid,
    input  logic                       bf_ready,
    output logic [P*N_LOG2-1:0]        bf_addr_a,
    output logic [P*N_LOG2-1:0]        bf_addr_b,
    output logic [P*(N_LOG2-1)-1:0]    bf_tw,
    output logic                       bf_last,
    input  logic                       wb_ack,
    output logic [1:0]                 dbg_state_o
);

    localparam int BEATS = (1 << (N_LOG2 - 1)) / P;
    localparam int JW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OW    = $clog2(BEATS + 1);
    localparam int TW    = N_LOG2 - 1;
    localparam logic [JW-1:0]     J_LAST     = JW'(BEATS - 1);
    localparam logic [N_LOG2-1:0] STAGE_LAST = N_LOG2'(N_LOG2 - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  state_q;
    logic [N_LOG2-1:0]       stage_q;
    logic [JW-1:0]           j_q;
    logic [OW-1:0]           out_q;
    logic                    busy_q, done_q, err_q, valid_q, last_q;
    logic [P*N_LOG2-1:0]     addr_a_q, addr_b_q;
    logic [P*TW-1:0]         tw_q;
    logic                    fire;

    assign fire = valid_q && bf_ready;

    // Butterfly b = j*P + l of stage st pairs a with a + 2^st, where a keeps
    // the low st bits of b and opens a zero gap at bit st.
    function automatic logic [P*N_LOG2-1:0] gen_a(input int st, input int jj);
        logic [P*N_LOG2-1:0] r;
        int b;
        int a;
        r = '0;
        for (int l = 0; l < P; l++) begin
            b = jj * P + l;
            a = ((b >> st) << (st + 1)) | (b & ((1 << st) - 1));
            r[l*N_LOG2 +: N_LOG2] = a[N_LOG2-1:0];
        end
        return r;
    endfunction

    function automatic logic [P*N_LOG2-1:0] gen_b(input int st, input int jj);
        logic [P*N_LOG2-1:0] r;
        int b;
        int a;
        r = '0;
        for (int l = 0; l < P; l++) begin
            b = jj * P + l;
            a = (((b >> st) << (st + 1)) | (b & ((1 << st) - 1))) + (1 << st);
            r[l*N_LOG2 +: N_LOG2] = a[N_LOG2-1:0];
        end
        return r;
    endfunction

    function automatic logic [P*TW-1:0] gen_tw(input int st, input int jj);
        logic [P*TW-1:0] r;
        int b;
        int t;
        r = '0;
        for (int l = 0; l < P; l++) begin
            b = jj * P + l;
            t = (b & ((1 << st) - 1)) << (TW - st);
            r[l*TW +: TW] = t[TW-1:0];
        end
        return r;
    endfunction

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q  <= S_IDLE;
            stage_q  <= '0;
            j_q      <= '0;
            out_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            tw_q     <= '0;
        end else begin
            done_q <= 1'b0;

            // Outstanding write-backs, tracked in every state. A fire and an
            // ack in the same cycle cancel out.
            if (fire && !wb_ack) begin
                out_q <= out_q + OW'(1);
            end else if (!fire && wb_ack) begin
                if (out_q == '0) begin
                    err_q <= 1'b1;
                end else begin
                    out_q <= out_q - OW'(1);
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        // Later assignments override the counter update above.
                        state_q  <= S_ISSUE;
                        stage_q  <= '0;
                        j_q      <= '0;
                        out_q    <= '0;
                        err_q    <= 1'b0;
                        busy_q   <= 1'b1;
                        valid_q  <= 1'b1;
                        last_q   <= (BEATS == 1);
                        addr_a_q <= gen_a(0, 0);
                        addr_b_q <= gen_b(0, 0);
                        tw_q     <= gen_tw(0, 0);
                    end
                end
                S_ISSUE: begin
                    if (fire) begin
                        if (j_q == J_LAST) begin
                            state_q <= S_DRAIN;
                            j_q     <= '0;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                        end else begin
                            j_q      <= j_q + JW'(1);
                            last_q   <= ((j_q + JW'(1)) == J_LAST);
                            addr_a_q <= gen_a(int'(stage_q), int'(j_q) + 1);
                            addr_b_q <= gen_b(int'(stage_q), int'(j_q) + 1);
                            tw_q     <= gen_tw(int'(stage_q), int'(j_q) + 1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (out_q == '0) begin
                        if (stage_q != STAGE_LAST) begin
                            state_q  <= S_ISSUE;
                            stage_q  <= stage_q + N_LOG2'(1);
                            valid_q  <= 1'b1;
                            last_q   <= (BEATS == 1);
                            addr_a_q <= gen_a(int'(stage_q) + 1, 0);
                            addr_b_q <= gen_b(int'(stage_q) + 1, 0);
                            tw_q     <= gen_tw(int'(stage_q) + 1, 0);
                        end else begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign stage       = stage_q;
    assign bf_valid    = valid_q;
    assign bf_last     = last_q;
    assign bf_addr_a   = addr_a_q;
    assign bf_addr_b   = addr_b_q;
    assign bf_tw       = tw_q;
    assign dbg_state_o = state_q;

endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Control sequencer for the parallel-butterfly FFT datapath. It walks all log2(N) radix-2 DIT stages and issues P butterflies per beat over a valid/ready handshake, each with its operand addresses and twiddle index. It drains outstanding write-backs at every stage boundary. It sits between the AXI4-Lite register block (which provides `start` and reads `busy`/`done`/`err`) and the butterfly array with its working memory.

## Interface
Parameters:
- `N_LOG2`, default 4: log2 of FFT length N; legal range 2..10.
- `P`, default 2: butterflies issued per beat; power of two, 1 ≤ P ≤ N/2.

Ports:
- `ACLK`  in  1  sole clock; all state updates on the rising edge.
- `ARESET`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a transform; sampled in IDLE only.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  single-cycle pulse when the transform completes.
- `err`  out  1  sticky; set on `wb_ack` with nothing outstanding; cleared on accepted `start`.
- `stage`  out  N_LOG2  current stage index, 0..N_LOG2-1.
- `bf_valid`  out  1  beat available.
- `bf_ready`  in  1  datapath accepts beat.
- `bf_addr_a`  out  P*N_LOG2  lane l in bits [l*N_LOG2 +: N_LOG2]; upper operand index.
- `bf_addr_b`  out  P*N_LOG2  lower operand index, per lane.
- `bf_tw`  out  P*(N_LOG2-1)  twiddle index per lane.
- `bf_last`  out  1  marks the final beat of the current stage.
- `wb_ack`  in  1  one pulse per beat whose results are written back.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - `start`=1 → ISSUE.
  - On that transition: `stage`=0, beat counter j=0, outstanding=0, `err`=0.
  - `start` is ignored in every other state.
- ISSUE:
  - `bf_valid`=1. A beat fires when `bf_valid`&`bf_ready`.
  - On fire: j increments and outstanding increments.
  - When the last beat fires (j = N/(2P)-1), go to DRAIN and set j=0.
- DRAIN:
  - `bf_valid`=0. Wait until the registered outstanding count equals 0.
  - Then, if `stage` < N_LOG2-1: increment `stage` → ISSUE.
  - Otherwise → DONE.
- DONE: `done`=1 for one cycle, `busy`=0 → IDLE.
- Address generation, for lane l of beat j:
  - b = j*P + l; span = 2^stage.
  - a = ((b >> stage) << (stage+1)) | (b & (span-1)).
  - `bf_addr_a` = a; `bf_addr_b` = a + span.
  - `bf_tw` = (b & (span-1)) << (N_LOG2-1-stage), truncated to N_LOG2-1 bits.
  - Outputs are a registered function of (`stage`, j); stable while `bf_valid`=1 and `bf_ready`=0.
- Outstanding counter:
  - Width clog2(N/(2P)+1).
  - Fire and `wb_ack` in the same cycle: counter unchanged.
  - `wb_ack` while the counter is 0: counter stays 0 and `err` is set.
  - `wb_ack` is accepted in every state.
- `busy` = state ∈ {ISSUE, DRAIN}.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `err`=0, `stage`=0, `bf_valid`=0, `bf_last`=0, `bf_addr_a`/`bf_addr_b`/`bf_tw`=0, counters=0.
- `ARESET` asserted mid-transform: everything returns to reset values immediately. No `done` is produced, and pending `wb_ack` pulses after release are treated as errors.
- Latency from `start`:
  - `busy` and `bf_valid` go high on the first edge after `start` is sampled.
  - With `bf_ready`=1 continuously, one beat fires per cycle: N/(2P) beats per stage.
- Stage boundary: ISSUE→ISSUE takes at least one DRAIN cycle. With write-back latency L cycles after each fire, drain lasts L cycles after the last fire.
- `bf_last` is high exactly on the last-beat cycle(s) of each stage, including stall cycles.
- `bf_valid` never drops without a fire (AXI-style rule).

## Test plan
- Reset, then N_LOG2=4, P=2, `bf_ready`=1, `wb_ack` one cycle after each fire:
  - Stage 0 beat 0: a={0,2}, b={1,3}, tw={0,0}.
  - Stage 1 beat 0: a={0,1}, b={2,3}, tw={0,4}.
  - Stage 3 beat 3: a={6,7}, b={14,15}, tw={6,7}.
  - 16 fires total, then `done` pulses once and `err`=0.
- Backpressure: `bf_ready` random 50%. Outputs are held while stalled, the address sequence matches the no-stall run, and there are exactly 16 fires.
- Drain: hold `wb_ack` off for 20 cycles at the end of stage 0. `stage` stays 0, `bf_valid`=0, and ISSUE resumes only after 4 acks.
- Fire and `wb_ack` in the same cycle (L=0 pipelined): outstanding never exceeds 1 and the stage advances correctly.
- Spurious `wb_ack` in IDLE: `err`=1 and stays set until the next `start`, which clears it. A `start` while busy is ignored, giving a single `done`.
- `ARESET` pulse during stage 2: all outputs return to reset values. A new `start` restarts at stage 0, beat 0.
